// File: rtl/pwm_demod_pkg.sv
// Shared definitions for the PWM transmit/receive pair.
//   - state_e: receiver FSM states (HUNT, MEASURE)
//   - DEFAULT_CYCLES_PER_WINDOW: window length shared with the dac transmitter
//   - sat_code(): clamp a window high-count to the largest representable code
package pwm_pkg;

  typedef enum logic [0:0] {
    HUNT    = 1'b0,
    MEASURE = 1'b1
  } state_e;

  localparam int DEFAULT_CYCLES_PER_WINDOW = 1024;

  // A window that is high on every cycle counts CYCLES_PER_WINDOW, one more
  // than the code width can hold; clamp it to the top code instead of wrapping.
  // Operates on 32-bit values so one helper serves any CODE_WIDTH; the caller
  // truncates the result to its own code width.
  function automatic logic [31:0] sat_code(input logic [31:0] count,
                                           input logic [31:0] max_code);
    logic [31:0] result;
    if (count > max_code) begin
      result = max_code;
    end else begin
      result = count;
    end
    return result;
  endfunction

endpackage

// File: rtl/pwm_demod_sync_edge.sv
// Input synchronizer followed by a rising-edge detector.
// Ports:
//   clk    in   system clock
//   reset  in   synchronous active-high reset; clears all flops
//   din_i  in   asynchronous (or same-clock) 1-bit input
//   p      out  synchronized sample of din_i (SYNC_STAGES cycles late)
//   rise   out  p & ~p_prev: high in the cycle p first goes high
// SYNC_STAGES = 0 bypasses the synchronizer (for same-clock sources).
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din_i,
  output logic p,
  output logic rise
);

  logic p_prev_q;

  generate
    if (SYNC_STAGES == 0) begin : g_bypass
      assign p = din_i;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;

      // Shift register synchronizer; stage 0 captures the raw input.
      always_ff @(posedge clk) begin
        if (reset) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= din_i;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end

      assign p = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Previous-sample flop for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      p_prev_q <= 1'b0;
    end else begin
      p_prev_q <= p;
    end
  end

  assign rise = p & ~p_prev_q;

endmodule

// File: rtl/pwm_demod.sv
// PWM demodulator: recovers the per-window duty code from a 1-bit PWM stream.
// Locks to the window boundary on a rising edge, counts high cycles across
// CYCLES_PER_WINDOW positions and reports the count with a 1-cycle strobe.
// Ports:
//   clk         in   system clock
//   reset       in   synchronous active-high reset
//   pwm         in   PWM input stream
//   code        out  recovered duty code, held between strobes
//   code_valid  out  1-cycle strobe: code updated this cycle
//   locked      out  high while aligned to window boundaries
//   sync_err    out  1-cycle strobe: rising edge seen mid-window
// All outputs come straight from flops.
module pwm_demod
  import pwm_pkg::*;
#(
  parameter int CYCLES_PER_WINDOW = DEFAULT_CYCLES_PER_WINDOW,
  parameter int CODE_WIDTH        = $clog2(CYCLES_PER_WINDOW),
  parameter int SYNC_STAGES       = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pwm,
  output logic [CODE_WIDTH-1:0] code,
  output logic                  code_valid,
  output logic                  locked,
  output logic                  sync_err
);

  // Counters are one bit wider than the code so a full-window count of
  // CYCLES_PER_WINDOW is representable before saturation.
  localparam logic [CODE_WIDTH:0] LAST_POS = (CODE_WIDTH+1)'(CYCLES_PER_WINDOW - 1);
  localparam logic [CODE_WIDTH:0] ONE      = (CODE_WIDTH+1)'(1);

  logic                  p_s;
  logic                  rise_s;
  logic [CODE_WIDTH:0]   hcnt_inc_d;

  state_e                state_q;
  logic [CODE_WIDTH:0]   wcnt_q;
  logic [CODE_WIDTH:0]   hcnt_q;
  logic [CODE_WIDTH-1:0] code_q;
  logic                  code_valid_q;
  logic                  locked_q;
  logic                  sync_err_q;

  sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk   (clk),
    .reset (reset),
    .din_i (pwm),
    .p     (p_s),
    .rise  (rise_s)
  );

  // High count including the current sample.
  assign hcnt_inc_d = hcnt_q + (CODE_WIDTH+1)'(p_s);

  // Window-tracking FSM with registered outputs. wcnt_q holds the window
  // position of the current sample; 0 means a new window starts here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= HUNT;
      wcnt_q       <= '0;
      hcnt_q       <= '0;
      code_q       <= '0;
      code_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      code_valid_q <= 1'b0;
      sync_err_q   <= 1'b0;
      case (state_q)
        HUNT: begin
          // The edge cycle is position 0 and is itself a high sample.
          if (rise_s) begin
            state_q <= MEASURE;
            wcnt_q  <= ONE;
            hcnt_q  <= ONE;
          end else begin
            state_q <= HUNT;
          end
        end
        MEASURE: begin
          if (rise_s && (wcnt_q != '0)) begin
            // Edge off the expected boundary: drop the partial window and
            // restart with this cycle as position 0.
            sync_err_q <= 1'b1;
            locked_q   <= 1'b0;
            wcnt_q     <= ONE;
            hcnt_q     <= ONE;
          end else if (wcnt_q == LAST_POS) begin
            // Last position: publish and restart at position 0 next cycle,
            // where the generic increment yields wcnt = 1, hcnt = p.
            code_q       <= CODE_WIDTH'(sat_code(32'(hcnt_inc_d),
                                                 32'(CYCLES_PER_WINDOW - 1)));
            code_valid_q <= 1'b1;
            locked_q     <= 1'b1;
            wcnt_q       <= '0;
            hcnt_q       <= '0;
          end else begin
            wcnt_q <= wcnt_q + ONE;
            hcnt_q <= hcnt_inc_d;
          end
        end
        default: begin
          state_q <= HUNT;
        end
      endcase
    end
  end

  assign code       = code_q;
  assign code_valid = code_valid_q;
  assign locked     = locked_q;
  assign sync_err   = sync_err_q;

endmodule
